// File: rtl/csr_pkg.sv
//------------------------------------------------------------------------------
// Module   : csr_pkg
// Purpose  : Shared CSR op encodings, FSM state type and width defaults.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package csr_pkg;

   localparam int CSR_ROBID_W = 7;
   localparam int CSR_OP_W    = 5;
   localparam int CSR_RD_W    = 6;

   localparam logic [CSR_OP_W-1:0] CSR_OP_NOP = 5'd0;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RW  = 5'd1;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RS  = 5'd2;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RC  = 5'd3;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RWI = 5'd5;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RSI = 5'd6;
   localparam logic [CSR_OP_W-1:0] CSR_OP_RCI = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } csr_state_e;

   // Queue entry layout is {op, robid, rd, op1, op2}, op2 in the LSBs.
   function automatic int csr_payload_w(input int robid_w, input int op_w);
      return op_w + robid_w + CSR_RD_W + 64;
   endfunction

endpackage

`default_nettype wire

// File: rtl/csr_fifo.sv
//------------------------------------------------------------------------------
// Module   : csr_fifo
// Purpose  : Generic DEPTH-entry synchronous FIFO with clear and head output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [WIDTH-1:0]           o_rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   // A push while full is dropped even if a pop lands in the same cycle.
   assign w_push  = i_push && !w_full && !i_clear;
   assign w_pop   = i_pop && !w_empty && !i_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/csr_serializer.sv
//------------------------------------------------------------------------------
// Module   : csr_serializer
// Purpose  : Holds CSR ops from rename and issues them one at a time once
//            they reach the ROB head; tracks the outstanding op to writeback.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_serializer
   import csr_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ROBID_W = CSR_ROBID_W,
   parameter int OP_W    = CSR_OP_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rename_csr_write,
   input  logic [OP_W-1:0]    rename_op,
   input  logic [ROBID_W-1:0] rename_robid,
   input  logic [5:0]         rename_rd,
   input  logic [31:0]        rename_op1,
   input  logic [31:0]        rename_op2,
   output logic               csrq_full,
   input  logic [ROBID_W-1:0] rob_head_robid,
   input  logic               rob_flush,
   input  logic               rob_csr_valid,
   output logic               issue_valid,
   output logic [OP_W-1:0]    issue_op,
   output logic [ROBID_W-1:0] issue_robid,
   output logic [5:0]         issue_rd,
   output logic [31:0]        issue_op1,
   output logic [31:0]        issue_op2,
   input  logic               csr_valid,
   input  logic [ROBID_W-1:0] csr_robid,
   output logic               csrq_busy
);

   localparam int PAYLOAD_W = csr_payload_w(ROBID_W, OP_W);
   localparam int ROBID_LSB = 64 + CSR_RD_W;
   localparam int OP_LSB    = ROBID_LSB + ROBID_W;

   logic [PAYLOAD_W-1:0]     w_wdata;
   logic [PAYLOAD_W-1:0]     w_head;
   logic                     w_full;
   logic                     w_empty;
   logic [$clog2(DEPTH):0]   w_count;
   logic                     w_enq;
   logic                     w_pop;
   logic                     w_head_match;

   logic [OP_W-1:0]    w_head_op;
   logic [ROBID_W-1:0] w_head_robid;
   logic [5:0]         w_head_rd;
   logic [31:0]        w_head_op1;
   logic [31:0]        w_head_op2;

   csr_state_e         r_state;
   logic               r_issue_valid;
   logic               r_busy;
   logic [OP_W-1:0]    r_issue_op;
   logic [ROBID_W-1:0] r_issue_robid;
   logic [5:0]         r_issue_rd;
   logic [31:0]        r_issue_op1;
   logic [31:0]        r_issue_op2;

   assign w_wdata = {rename_op, rename_robid, rename_rd, rename_op1, rename_op2};

   assign w_head_op2   = w_head[31:0];
   assign w_head_op1   = w_head[63:32];
   assign w_head_rd    = w_head[64 +: CSR_RD_W];
   assign w_head_robid = w_head[ROBID_LSB +: ROBID_W];
   assign w_head_op    = w_head[OP_LSB +: OP_W];

   assign w_enq = rename_csr_write && !w_full && !rob_flush;

   // Writeback retires the head entry; stray robids and flush-cycle writebacks are ignored.
   assign w_pop = (r_state == ST_BUSY) && csr_valid && (csr_robid == w_head_robid)
                  && !rob_flush;

   assign w_head_match = !w_empty && (w_head_robid == rob_head_robid)
                         && !rob_flush && !rob_csr_valid;

   csr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PAYLOAD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_enq),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .i_clear (rob_flush),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_rdata (w_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_issue_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_issue_op    <= '0;
         r_issue_robid <= '0;
         r_issue_rd    <= '0;
         r_issue_op1   <= '0;
         r_issue_op2   <= '0;
      end else if (rob_flush) begin
         // Issue data registers keep their contents; they are ignored while idle.
         r_state       <= ST_IDLE;
         r_issue_valid <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_issue_valid <= 1'b0;
               r_busy        <= 1'b0;
               if (w_head_match) begin
                  r_state       <= ST_ISSUE;
                  r_issue_valid <= 1'b1;
                  r_busy        <= 1'b1;
                  r_issue_op    <= w_head_op;
                  r_issue_robid <= w_head_robid;
                  r_issue_rd    <= w_head_rd;
                  r_issue_op1   <= w_head_op1;
                  r_issue_op2   <= w_head_op2;
               end
            end
            ST_ISSUE: begin
               r_state       <= ST_BUSY;
               r_issue_valid <= 1'b0;
               r_busy        <= 1'b1;
            end
            ST_BUSY: begin
               r_issue_valid <= 1'b0;
               if (w_pop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_issue_valid <= 1'b0;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

   assign csrq_full   = w_full;
   assign csrq_busy   = r_busy;
   assign issue_valid = r_issue_valid;
   assign issue_op    = r_issue_op;
   assign issue_robid = r_issue_robid;
   assign issue_rd    = r_issue_rd;
   assign issue_op1   = r_issue_op1;
   assign issue_op2   = r_issue_op2;

endmodule

`default_nettype wire

// File: tb/tb_csr_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_csr_serializer
// Purpose  : Directed self-checking bench for csr_serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_csr_serializer;
   import csr_pkg::*;

   localparam int RW = 7;
   localparam int OW = 5;

   logic          clk;
   logic          rst;
   logic          rename_csr_write;
   logic [OW-1:0] rename_op;
   logic [RW-1:0] rename_robid;
   logic [5:0]    rename_rd;
   logic [31:0]   rename_op1;
   logic [31:0]   rename_op2;
   logic          csrq_full;
   logic [RW-1:0] rob_head_robid;
   logic          rob_flush;
   logic          rob_csr_valid;
   logic          issue_valid;
   logic [OW-1:0] issue_op;
   logic [RW-1:0] issue_robid;
   logic [5:0]    issue_rd;
   logic [31:0]   issue_op1;
   logic [31:0]   issue_op2;
   logic          csr_valid;
   logic [RW-1:0] csr_robid;
   logic          csrq_busy;

   int n_cmp = 0;
   int n_err = 0;
   int v_b2b = 0;
   int v_pop = 0;
   bit prev_iv = 1'b0;

   csr_serializer #(.DEPTH(4), .ROBID_W(RW), .OP_W(OW)) dut (
      .clk              (clk),
      .rst              (rst),
      .rename_csr_write (rename_csr_write),
      .rename_op        (rename_op),
      .rename_robid     (rename_robid),
      .rename_rd        (rename_rd),
      .rename_op1       (rename_op1),
      .rename_op2       (rename_op2),
      .csrq_full        (csrq_full),
      .rob_head_robid   (rob_head_robid),
      .rob_flush        (rob_flush),
      .rob_csr_valid    (rob_csr_valid),
      .issue_valid      (issue_valid),
      .issue_op         (issue_op),
      .issue_robid      (issue_robid),
      .issue_rd         (issue_rd),
      .issue_op1        (issue_op1),
      .issue_op2        (issue_op2),
      .csr_valid        (csr_valid),
      .csr_robid        (csr_robid),
      .csrq_busy        (csrq_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Protocol monitors: no back-to-back issue, pop only while BUSY.
   always @(negedge clk) begin
      if (rst) begin
         prev_iv = 1'b0;
      end else begin
         if (issue_valid && prev_iv) v_b2b++;
         if (dut.w_pop && (dut.r_state != ST_BUSY)) v_pop++;
         prev_iv = issue_valid;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [RW-1:0] robid, input logic [OW-1:0] op,
                      input logic [5:0] rd, input logic [31:0] a, input logic [31:0] b);
      rename_csr_write = 1'b1;
      rename_robid     = robid;
      rename_op        = op;
      rename_rd        = rd;
      rename_op1       = a;
      rename_op2       = b;
      step();
      rename_csr_write = 1'b0;
   endtask

   task automatic wait_issue(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (issue_valid) seen = 1'b1;
      end
   endtask

   task automatic writeback(input logic [RW-1:0] robid);
      csr_valid = 1'b1;
      csr_robid = robid;
      step();
      csr_valid = 1'b0;
   endtask

   bit seen;
   int hits;

   initial begin
      rst = 1'b1;
      rename_csr_write = 1'b0;
      rename_op = '0; rename_robid = '0; rename_rd = '0;
      rename_op1 = '0; rename_op2 = '0;
      rob_head_robid = '0; rob_flush = 1'b0; rob_csr_valid = 1'b0;
      csr_valid = 1'b0; csr_robid = '0;
      step();
      step();
      chk("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
      chk("rst_busy",        {63'd0, csrq_busy},   64'd0);
      chk("rst_full",        {63'd0, csrq_full},   64'd0);
      chk("rst_issue_data",  {issue_op1, issue_op2}, 64'd0);
      rst = 1'b0;
      step();
      chk("rst_count", 64'(dut.u_fifo.r_count), 64'd0);

      // Single op: issue in the 2nd cycle after the enqueue strobe.
      rob_head_robid = 7'd5;
      enq(7'd5, CSR_OP_RW, 6'd17, 32'hDEAD_BEEF, 32'h0000_0300);
      chk("single_no_issue_yet", {63'd0, issue_valid}, 64'd0);
      step();
      chk("single_issue_valid", {63'd0, issue_valid}, 64'd1);
      chk("single_issue_robid", 64'(issue_robid), 64'd5);
      chk("single_issue_op",    64'(issue_op), 64'(CSR_OP_RW));
      chk("single_issue_rd",    64'(issue_rd), 64'd17);
      chk("single_issue_ops",   {issue_op1, issue_op2}, 64'hDEAD_BEEF_0000_0300);
      chk("single_busy_issue",  {63'd0, csrq_busy}, 64'd1);
      step();
      chk("single_pulse_drop",  {63'd0, issue_valid}, 64'd0);
      chk("single_busy_busy",   {63'd0, csrq_busy}, 64'd1);
      writeback(7'd6);
      chk("single_bad_wb_busy", {63'd0, csrq_busy}, 64'd1);
      chk("single_bad_wb_cnt",  64'(dut.u_fifo.r_count), 64'd1);
      writeback(7'd5);
      chk("single_wb_busy",     {63'd0, csrq_busy}, 64'd0);
      chk("single_wb_count",    64'(dut.u_fifo.r_count), 64'd0);
      wait_issue(3, seen);
      chk("single_no_reissue",  {63'd0, seen}, 64'd0);

      // Wait for head.
      rob_head_robid = 7'd3;
      enq(7'd9, CSR_OP_RS, 6'd2, 32'h1, 32'h2);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (issue_valid) hits++;
      end
      chk("head_wait_no_issue", 64'(hits), 64'd0);
      rob_head_robid = 7'd9;
      step();
      chk("head_issue_valid", {63'd0, issue_valid}, 64'd1);
      chk("head_issue_robid", 64'(issue_robid), 64'd9);
      step();
      writeback(7'd9);
      chk("head_done_count", 64'(dut.u_fifo.r_count), 64'd0);

      // Fill and drain in order; the 5th enqueue is dropped.
      rob_head_robid = 7'd0;
      for (int k = 1; k <= 4; k++) begin
         enq(7'(k), CSR_OP_RC, 6'(k), 32'(k * 16), 32'(k));
      end
      chk("fill_full",  {63'd0, csrq_full}, 64'd1);
      enq(7'd7, CSR_OP_RC, 6'd7, 32'h70, 32'h7);
      chk("fill_drop_count", 64'(dut.u_fifo.r_count), 64'd4);
      chk("fill_still_full", {63'd0, csrq_full}, 64'd1);
      for (int k = 1; k <= 4; k++) begin
         rob_head_robid = 7'(k);
         wait_issue(4, seen);
         chk("drain_seen",  {63'd0, seen}, 64'd1);
         chk("drain_robid", 64'(issue_robid), 64'(k));
         chk("drain_op1",   64'(issue_op1), 64'(k * 16));
         step();
         writeback(7'(k));
      end
      chk("drain_count", 64'(dut.u_fifo.r_count), 64'd0);
      chk("drain_not_full", {63'd0, csrq_full}, 64'd0);
      rob_head_robid = 7'd7;
      wait_issue(4, seen);
      chk("drain_dropped_absent", {63'd0, seen}, 64'd0);

      // Flush in BUSY, with a same-cycle enqueue and a late writeback.
      rob_head_robid = 7'd2;
      enq(7'd2, CSR_OP_RWI, 6'd4, 32'h5, 32'h6);
      step();
      chk("flush_pre_issue", {63'd0, issue_valid}, 64'd1);
      step();
      chk("flush_pre_busy", {63'd0, csrq_busy}, 64'd1);
      rob_flush = 1'b1;
      rename_csr_write = 1'b1;
      rename_robid = 7'd2;
      step();
      rob_flush = 1'b0;
      rename_csr_write = 1'b0;
      chk("flush_busy",  {63'd0, csrq_busy}, 64'd0);
      chk("flush_state", 64'(dut.r_state), 64'(ST_IDLE));
      chk("flush_count", 64'(dut.u_fifo.r_count), 64'd0);
      writeback(7'd2);
      chk("flush_no_underflow", 64'(dut.u_fifo.r_count), 64'd0);
      wait_issue(4, seen);
      chk("flush_no_issue", {63'd0, seen}, 64'd0);

      // Trap inhibit only blocks the IDLE->ISSUE step.
      rob_head_robid = 7'd11;
      rob_csr_valid = 1'b1;
      enq(7'd11, CSR_OP_RSI, 6'd8, 32'h8, 32'h9);
      step();
      chk("trap_block1", {63'd0, issue_valid}, 64'd0);
      step();
      chk("trap_block2", {63'd0, issue_valid}, 64'd0);
      rob_csr_valid = 1'b0;
      step();
      chk("trap_release_issue", {63'd0, issue_valid}, 64'd1);
      rob_csr_valid = 1'b1;
      step();
      chk("trap_busy", {63'd0, csrq_busy}, 64'd1);
      writeback(7'd11);
      chk("trap_wb_done", {63'd0, csrq_busy}, 64'd0);
      rob_csr_valid = 1'b0;

      // Async reset while in ISSUE with a full queue.
      rob_head_robid = 7'd0;
      for (int k = 20; k <= 23; k++) begin
         enq(7'(k), CSR_OP_RCI, 6'd1, 32'(k), 32'(k));
      end
      rob_head_robid = 7'd20;
      step();
      chk("areset_pre_issue", {63'd0, issue_valid}, 64'd1);
      chk("areset_pre_full",  {63'd0, csrq_full}, 64'd1);
      #3 rst = 1'b1;
      #1;
      chk("areset_issue_valid", {63'd0, issue_valid}, 64'd0);
      chk("areset_busy",        {63'd0, csrq_busy}, 64'd0);
      chk("areset_full",        {63'd0, csrq_full}, 64'd0);
      chk("areset_issue_robid", 64'(issue_robid), 64'd0);
      #1 rst = 1'b0;
      step();
      chk("areset_count", 64'(dut.u_fifo.r_count), 64'd0);
      wait_issue(4, seen);
      chk("areset_empty_no_issue", {63'd0, seen}, 64'd0);

      chk("assert_b2b_issue", 64'(v_b2b), 64'd0);
      chk("assert_pop_busy",  64'(v_pop), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/csr_serializer.md
Name: csr_serializer

Overview:
- Buffers CSR instructions dispatched from rename and releases them to the csr unit one at a time.
- An instruction is released only once it is non-speculative, i.e. its robid is at the ROB head.
- Sits between rename and the csr datapath, and tracks the single outstanding op until the csr unit writes back.
- On a ROB flush it discards all buffered and in-flight state.

Parameters:
DEPTH, 4, number of buffered CSR ops (power of two, >=2)
ROBID_W, 7, ROB id width
OP_W, 5, CSR op encoding width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rename_csr_write  in  1  enqueue strobe from rename
rename_op  in  OP_W  CSR op
rename_robid  in  ROBID_W  ROB id of op
rename_rd  in  6  physical destination
rename_op1  in  32  operand 1 (rs1 value / zimm)
rename_op2  in  32  operand 2 (CSR address in [11:0])
csrq_full  out  1  backpressure to rename
rob_head_robid  in  ROBID_W  robid currently at ROB head
rob_flush  in  1  pipeline flush
rob_csr_valid  in  1  trap commit in progress; inhibits issue this cycle
issue_valid  out  1  one-cycle issue pulse to csr unit
issue_op  out  OP_W  issued op
issue_robid  out  ROBID_W  issued robid
issue_rd  out  6  issued destination
issue_op1  out  32  issued operand 1
issue_op2  out  32  issued operand 2
csr_valid  in  1  csr unit writeback
csr_robid  in  ROBID_W  robid of writeback
csrq_busy  out  1  an op is issued and not yet written back

Behaviour:
- Reset (async, rst=1): count=0, rd/wr pointers=0, state=IDLE. issue_valid=0, csrq_busy=0, csrq_full=0. All issue_* data outputs=0.
- Queue: FIFO of {op, robid, rd, op1, op2}; pointers wrap modulo DEPTH; count is 0..DEPTH.
- csrq_full = (count==DEPTH), combinational from count.
  - A pop in the same cycle does not deassert csrq_full that cycle.
  - Enqueue while full is dropped and count is unchanged; rename must never do this.
- Enqueue: rename_csr_write && !full && !rob_flush; the entry is written at the clk edge.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE -> ISSUE when count>0 && head.robid==rob_head_robid && !rob_flush && !rob_csr_valid. The head entry is latched into the issue_* registers.
  - ISSUE: issue_valid=1 for exactly this cycle, then unconditionally -> BUSY (unless flushed).
  - BUSY: csrq_busy=1.
    - csr_valid && csr_robid==head.robid: pop head, -> IDLE.
    - csr_valid with a mismatching robid is ignored and the state stays BUSY.
  - csrq_busy is also 1 in ISSUE.
- Latency: ROB-head match seen in cycle N -> issue_valid in N+1 -> earliest pop in N+2. Back-to-back CSR ops issue at most once every 3 cycles.
- Pop and enqueue in the same cycle: count is unchanged and both pointers advance.
- rob_flush (synchronous, highest priority):
  - count=0, pointers=0, state=IDLE, issue_valid=0 in the next cycle.
  - An enqueue in the same cycle is dropped.
  - A csr_valid arriving in or after the flush cycle is ignored.
  - The issue_* data registers hold their values; they are don't-care while issue_valid=0.
- rob_csr_valid only blocks the IDLE->ISSUE transition; it does not affect ISSUE or BUSY.
- Reset mid-operation: immediate return to the reset values regardless of state.
- Assertions for the bench:
  - No enqueue while full.
  - issue_valid is never high in two consecutive cycles.
  - Pop occurs only in BUSY.

Decomposition:
- Shared package csr_pkg:
  - CSR op encodings (OP_W-wide localparams).
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2).
  - The ROBID_W and OP_W defaults.
- Sub-module csr_fifo: a generic DEPTH-entry synchronous FIFO.
  - Interface: push, pop, clear, full, empty, head data.
  - Instanced with a 6+ROBID_W+OP_W+64-bit payload.
- The FSM and the issue registers live in csr_serializer.

Test Plan:
- Single op: enqueue robid=5 with rob_head_robid=5 -> issue_valid at the 2nd cycle after enqueue with issue_robid=5; csr_valid with csr_robid=5 -> csrq_busy=0 next cycle, count=0.
- Wait for head: enqueue robid=9 while rob_head_robid=3 for 10 cycles -> no issue_valid; head becomes 9 -> issue_valid one cycle later.
- Fill: 4 enqueues (robids 1..4), no issue -> csrq_full=1. 5th enqueue (robid 7) dropped; draining in order issues exactly 1,2,3,4.
- Flush in BUSY: issue robid=2, assert rob_flush, then csr_valid robid=2 -> count=0, state IDLE, no pop underflow, no further issue_valid.
- Trap inhibit: head match with rob_csr_valid=1 for 2 cycles -> no issue; rob_csr_valid drops -> issue_valid next cycle.
- Async reset during ISSUE: rst pulsed mid-cycle -> issue_valid, csrq_busy, csrq_full all 0 immediately; the queue is empty after reset.
